mopshub_rec_bus_arbiter: RTL and testbench

//  Round-robin scheduler sharing the single CAN-receive -> eLink uplink path among up to 32 CAN bus controllers.

---
 rtl/mopshub_rec_pkg.sv | 18 +
 rtl/mopshub_rr_pick.sv | 34 +++
 rtl/mopshub_rec_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mopshub_rec_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_rec_pkg.sv
// Shared types and default sizes for the MOPS-Hub CAN-receive uplink arbiter.
package mopshub_rec_pkg;

  localparam int          N_BUS_DEF       = 32;
  localparam int          SEL_W_DEF       = 5;
  localparam int          FRAME_W_DEF     = 76;
  localparam logic [15:0] ACK_TIMEOUT_DEF = 16'd4000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    CLR  = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/mopshub_rr_pick.sv
// Combinational round-robin finder: first eligible request after ptr, limited to indices <= n_buses.
module mopshub_rr_pick #(
  parameter int N_BUS = 32,
  parameter int SEL_W = $clog2(N_BUS)
) (
  input  logic [N_BUS-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [SEL_W-1:0] n_buses,
  output logic [SEL_W-1:0] pick,
  output logic             found
);

  logic [N_BUS-1:0] elig;

  for (genvar gi = 0; gi < N_BUS; gi++) begin : g_elig
    assign elig[gi] = req[gi] & (gi <= int'(n_buses));
  end

  // Scan from farthest to nearest so the last hit is the closest index after ptr.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = N_BUS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_BUS;
      if (elig[idx]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mopshub_rec_bus_arbiter.sv
// Round-robin scheduler sharing the CAN-receive -> eLink uplink path among the bus controllers.
module mopshub_rec_bus_arbiter
  import mopshub_rec_pkg::*;
#(
  parameter int          N_BUS       = N_BUS_DEF,
  parameter int          SEL_W       = $clog2(N_BUS),
  parameter int          FRAME_W     = FRAME_W_DEF,
  parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk_40_m,
  input  logic               rst,
  input  logic               enable,
  input  logic [SEL_W-1:0]   n_buses,
  input  logic [N_BUS-1:0]   irq_can_rec,
  output logic [N_BUS-1:0]   irq_clr,
  output logic [SEL_W-1:0]   can_rec_select,
  output logic               rec_read,
  input  logic               rec_data_vld,
  input  logic [FRAME_W-1:0] data_rec_in,
  output logic [FRAME_W-1:0] data_rec_uplink,
  output logic               uplink_vld,
  input  logic               uplink_rdy,
  output logic               busy,
  output logic               timeout_err,
  output logic [SEL_W-1:0]   timeout_bus,
  output logic [15:0]        served_cnt
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, ptr_q, ptr_d, tout_bus_q, tout_bus_d;
  logic [15:0]        timer_q, timer_d, served_q, served_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [N_BUS-1:0]   irq_clr_q, irq_clr_d;
  logic               rec_read_q, rec_read_d, uplink_vld_q, uplink_vld_d;
  logic               busy_q, busy_d, tout_err_q, tout_err_d;
  logic [SEL_W-1:0]   pick;
  logic               found;

  mopshub_rr_pick #(.N_BUS(N_BUS), .SEL_W(SEL_W)) u_pick (
    .req     (irq_can_rec),
    .ptr     (ptr_q),
    .n_buses (n_buses),
    .pick    (pick),
    .found   (found)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    data_d     = data_q;
    served_d   = served_q;
    tout_bus_d = tout_bus_q;
    irq_clr_d  = '0;

    case (state_q)
      IDLE: if (enable && found) begin
        state_d = REQ;
        sel_d   = pick;
      end
      REQ: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (rec_data_vld) begin
        data_d  = data_rec_in;
        state_d = SEND;
      end else if (timer_q == ACK_TIMEOUT - 16'd1) begin
        state_d = ERR;
      end else begin
        timer_d = timer_q + 16'd1;
      end
      SEND: if (uplink_rdy) state_d = CLR;
      CLR:  state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    rec_read_d   = (state_d == REQ);
    uplink_vld_d = (state_d == SEND);
    busy_d       = (state_d != IDLE);
    tout_err_d   = (state_d == ERR);
    if (state_d == CLR || state_d == ERR) begin
      irq_clr_d[sel_q] = 1'b1;
      ptr_d            = sel_q;
    end
    if (state_d == CLR && served_q != 16'hFFFF) served_d = served_q + 16'd1;
    if (state_d == ERR) tout_bus_d = sel_q;
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ptr_q        <= SEL_W'(N_BUS - 1);
      timer_q      <= '0;
      data_q       <= '0;
      served_q     <= '0;
      tout_bus_q   <= '0;
      irq_clr_q    <= '0;
      rec_read_q   <= 1'b0;
      uplink_vld_q <= 1'b0;
      busy_q       <= 1'b0;
      tout_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      served_q     <= served_d;
      tout_bus_q   <= tout_bus_d;
      irq_clr_q    <= irq_clr_d;
      rec_read_q   <= rec_read_d;
      uplink_vld_q <= uplink_vld_d;
      busy_q       <= busy_d;
      tout_err_q   <= tout_err_d;
    end
  end

  assign irq_clr         = irq_clr_q;
  assign can_rec_select  = sel_q;
  assign rec_read        = rec_read_q;
  assign data_rec_uplink = data_q;
  assign uplink_vld      = uplink_vld_q;
  assign busy            = busy_q;
  assign timeout_err     = tout_err_q;
  assign timeout_bus     = tout_bus_q;
  assign served_cnt      = served_q;

endmodule

// File: tb/tb_mopshub_rec_bus_arbiter.sv
// Self-checking bench: table of single-bus transactions plus hand sequences for timeout, stall, enable and reset.
module tb_mopshub_rec_bus_arbiter;

  localparam int NB = 32;
  localparam int SW = 5;
  localparam int FW = 76;

  logic          clk_40_m = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [SW-1:0] n_buses = 5'd31;
  logic [NB-1:0] irq_can_rec = '0;
  logic [NB-1:0] irq_clr;
  logic [SW-1:0] can_rec_select;
  logic          rec_read;
  logic          rec_data_vld = 1'b0;
  logic [FW-1:0] data_rec_in = '0;
  logic [FW-1:0] data_rec_uplink;
  logic          uplink_vld;
  logic          uplink_rdy = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic [SW-1:0] timeout_bus;
  logic [15:0]   served_cnt;

  mopshub_rec_bus_arbiter #(
    .N_BUS(NB), .SEL_W(SW), .FRAME_W(FW), .ACK_TIMEOUT(16'd16)
  ) dut (
    .clk_40_m        (clk_40_m),
    .rst             (rst),
    .enable          (enable),
    .n_buses         (n_buses),
    .irq_can_rec     (irq_can_rec),
    .irq_clr         (irq_clr),
    .can_rec_select  (can_rec_select),
    .rec_read        (rec_read),
    .rec_data_vld    (rec_data_vld),
    .data_rec_in     (data_rec_in),
    .data_rec_uplink (data_rec_uplink),
    .uplink_vld      (uplink_vld),
    .uplink_rdy      (uplink_rdy),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .timeout_bus     (timeout_bus),
    .served_cnt      (served_cnt)
  );

  always #5 clk_40_m = ~clk_40_m;

  int cyc = 0;
  always @(posedge clk_40_m) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_served = 0;
  logic [FW-1:0] sb_q[$];

  typedef struct {
    logic [NB-1:0] irq_set;
    logic [SW-1:0] exp_sel;
    int            vld_dly;
    int            rdy_dly;
    logic [FW-1:0] data;
    bit            drop;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rec_read(output bit seen);
    int w;
    w = 0;
    do begin
      @(negedge clk_40_m);
      w++;
    end while (rec_read !== 1'b1 && w < 60);
    seen = (rec_read === 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sel"}, can_rec_select, 0);
    chk({tag, "_rec_read"}, rec_read, 0);
    chk({tag, "_irq_clr"}, irq_clr, 0);
    chk({tag, "_uplink_vld"}, uplink_vld, 0);
    chk({tag, "_data"}, data_rec_uplink, 0);
    chk({tag, "_served"}, served_cnt, 0);
    chk({tag, "_tout"}, {timeout_err, timeout_bus}, 0);
  endtask

  task automatic quiet(input string name, input int n);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk_40_m);
      if (rec_read !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk(name, ok, 1);
  endtask

  // One full grant -> read -> send -> clear cycle for the expected bus.
  task automatic txn(input logic [SW-1:0] exp_sel, input int vld_dly, input int rdy_dly,
                     input logic [FW-1:0] data, input logic [NB-1:0] clr_mask,
                     input bit drop_early, input bit en_drop, output int rr_cyc);
    bit seen, stable;
    logic [FW-1:0] expd;
    logic [NB-1:0] exp_clr;
    expd    = '0;
    exp_clr = '0;
    exp_clr[exp_sel] = 1'b1;
    wait_rec_read(seen);
    rr_cyc = cyc;
    if (!seen) begin
      chk("rec_read_timeout", 0, 1);
      return;
    end
    chk("grant_sel", can_rec_select, exp_sel);
    chk("busy", busy, 1);
    if (drop_early) irq_can_rec &= ~clr_mask;
    if (en_drop) enable = 1'b0;
    @(negedge clk_40_m);
    chk("rec_read_pulse", rec_read, 0);
    repeat (vld_dly) @(negedge clk_40_m);
    rec_data_vld = 1'b1;
    data_rec_in  = data;
    sb_q.push_back(data);
    @(negedge clk_40_m);
    rec_data_vld = 1'b0;
    data_rec_in  = ~data;
    chk("uplink_vld", uplink_vld, 1);
    if (sb_q.size() > 0) begin
      expd = sb_q.pop_front();
      chk("uplink_data", data_rec_uplink, expd);
    end
    stable = 1'b1;
    repeat (rdy_dly) begin
      @(negedge clk_40_m);
      if (uplink_vld !== 1'b1 || data_rec_uplink !== expd || rec_read !== 1'b0 || irq_clr !== '0)
        stable = 1'b0;
    end
    if (rdy_dly > 0) chk("hold_stable", stable, 1);
    uplink_rdy = 1'b1;
    @(negedge clk_40_m);
    uplink_rdy = 1'b0;
    exp_served++;
    chk("irq_clr", irq_clr, exp_clr);
    chk("uplink_vld_drop", uplink_vld, 0);
    chk("served_cnt", served_cnt, exp_served);
    if (!drop_early) irq_can_rec &= ~clr_mask;
    @(negedge clk_40_m);
    chk("irq_clr_idle", irq_clr, 0);
    $display("txn bus=%0d vld_dly=%0d rdy_dly=%0d served=%0d at cycle %0d",
             exp_sel, vld_dly, rdy_dly, served_cnt, rr_cyc);
  endtask

  initial begin
    int r0, r1, r;
    bit seen;
    logic [NB-1:0] exp_clr;

    tbl[0] = '{32'h0000_0020, 5'd5,  2,  2, 76'hA_5A5A_5A5A_5A5A_5A5A_5, 1'b0};
    tbl[1] = '{32'h0000_0408, 5'd10, 0,  0, 76'h1_2345_6789_ABCD_EF01_2, 1'b0};
    tbl[2] = '{32'h0000_0000, 5'd3,  15, 1, 76'hF_0F0F_0F0F_0F0F_0F0F_0, 1'b0};
    tbl[3] = '{32'h0000_0006, 5'd1,  14, 0, 76'h3_C3C3_C3C3_C3C3_C3C3_C, 1'b1};
    tbl[4] = '{32'h0000_0000, 5'd2,  1,  3, 76'h8_0000_0000_0000_0000_1, 1'b0};
    tbl[5] = '{32'hC000_0000, 5'd30, 0,  0, 76'h7_FFFF_0000_FFFF_0000_7, 1'b0};
    tbl[6] = '{32'h0000_0000, 5'd31, 0,  0, 76'hD_EAD0_BEEF_CAFE_F00D_9, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_40_m);
    check_all_zero("reset");
    rst = 1'b1;
    enable = 1'b1;

    // Held requests on 0,3,31 with immediate handshakes: strict rotation, 5-cycle spacing
    irq_can_rec = 32'h8000_0009;
    txn(5'd0, 0, 0, 76'h1, '0, 1'b0, 1'b0, r0);
    txn(5'd3, 0, 0, 76'h2, '0, 1'b0, 1'b0, r1);
    chk("spacing_0_3", r1 - r0, 5);
    txn(5'd31, 0, 0, 76'h3, '0, 1'b0, 1'b0, r0);
    chk("spacing_3_31", r0 - r1, 5);
    txn(5'd0, 0, 0, 76'h4, '0, 1'b0, 1'b0, r1);
    chk("spacing_31_0", r1 - r0, 5);
    txn(5'd3, 0, 0, 76'h5, '1, 1'b0, 1'b0, r0);
    chk("spacing_0_3b", r0 - r1, 5);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      logic [NB-1:0] m;
      m = '0;
      m[tbl[i].exp_sel] = 1'b1;
      irq_can_rec |= tbl[i].irq_set;
      txn(tbl[i].exp_sel, tbl[i].vld_dly, tbl[i].rdy_dly, tbl[i].data, m, tbl[i].drop, 1'b0, r);
    end

    // n_buses limits service to buses 0..3
    n_buses = 5'd3;
    irq_can_rec |= 32'h0000_0084;
    txn(5'd2, 0, 0, 76'h22, 32'h4, 1'b0, 1'b0, r);
    quiet("masked_bus7", 20);
    irq_can_rec[7] = 1'b0;
    n_buses = 5'd31;

    // Long uplink stall: frame held, no second grant, pending bus served afterwards
    irq_can_rec |= 32'h0000_1002;
    txn(5'd12, 0, 100, 76'hB_EEF0_1234_5678_9ABC_D, 32'h1000, 1'b0, 1'b0, r);
    txn(5'd1, 0, 0, 76'h11, 32'h2, 1'b0, 1'b0, r);

    // Timeout: no rec_data_vld for bus 9
    irq_can_rec[9] = 1'b1;
    wait_rec_read(seen);
    chk("tout_grant_seen", seen, 1);
    chk("tout_grant_sel", can_rec_select, 9);
    r0 = cyc;
    for (int w = 0; w < 40 && timeout_err !== 1'b1; w++) @(negedge clk_40_m);
    exp_clr = '0;
    exp_clr[9] = 1'b1;
    chk("tout_latency", cyc - r0, 17);
    chk("tout_err", timeout_err, 1);
    chk("tout_bus", timeout_bus, 9);
    chk("tout_irq_clr", irq_clr, exp_clr);
    chk("tout_served", served_cnt, exp_served);
    irq_can_rec[9] = 1'b0;
    @(negedge clk_40_m);
    chk("tout_pulse", timeout_err, 0);
    chk("tout_bus_sticky", timeout_bus, 9);
    $display("txn bus=9 timeout at cycle %0d", cyc);

    // Enable gating: no grant while low; dropping it mid-transaction lets the transfer finish
    enable = 1'b0;
    irq_can_rec |= 32'h0000_0140;
    quiet("enable_low", 10);
    enable = 1'b1;
    txn(5'd6, 2, 1, 76'h66, 32'h40, 1'b0, 1'b1, r);
    quiet("enable_dropped", 10);
    enable = 1'b1;
    txn(5'd8, 0, 0, 76'h88, 32'h100, 1'b0, 1'b0, r);

    // Reset during SEND, then search restarts at bus 0
    irq_can_rec[4] = 1'b1;
    wait_rec_read(seen);
    chk("rst_seq_sel", can_rec_select, 4);
    @(negedge clk_40_m);
    rec_data_vld = 1'b1;
    data_rec_in  = 76'h4_4444_4444_4444_4444_4;
    @(negedge clk_40_m);
    rec_data_vld = 1'b0;
    chk("rst_seq_send", uplink_vld, 1);
    rst = 1'b0;
    @(negedge clk_40_m);
    check_all_zero("midrst");
    exp_served = 0;
    irq_can_rec = 32'h0000_0011;
    rst = 1'b1;
    txn(5'd0, 0, 0, 76'h100, 32'h1, 1'b0, 1'b0, r);
    txn(5'd4, 0, 0, 76'h104, 32'h10, 1'b0, 1'b0, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
